mult_op_sequencer: RTL and testbench
====================================

// Module: mult_op_sequencer
// PURPOSE
//  Upstream feeder for shift_add_mult. Buffers operand pairs from a valid/ready source in a FIFO.
//  Issues each pair to the multiplier as a one-cycle start (opcode 2'b01).
//  Waits for the multiplier's done indication, then holds the product on a valid/ready result port.
//  Processes one operation at a time. Results leave in arrival order.
// PARAMETERS
//  BW     4  operand width; product is 2*BW. Must equal the multiplier's BW.
//  DEPTH  4  operand FIFO entries; power of 2, >=2
// PORTS
//  clk              in   1     single clock, all state updates on posedge
//  reset            in   1     synchronous, active-high; integration drives multiplier resetn = ~reset
//  in_valid         in   1     operand pair valid
//  in_ready         out  1     FIFO can accept (= !full)
//  in_a             in   BW    multiplier operand
//  in_b             in   BW    multiplicand operand
//  out_valid        out  1     out_result valid
//  out_ready        in   1     consumer accepts result
//  out_result       out  2*BW  product a*b
//  mul_multiplier   out  BW    to multiplier; FIFO head a
//  mul_multiplicand out  BW    to multiplier; FIFO head b
//  mul_opcode       out  2     2'b01 in ISSUE only, else 2'b00
//  mul_result       in   2*BW  from multiplier
//  mul_ready        in   1     from multiplier; high in its idle state AND at completion
// BEHAVIOUR
//  Reset values: state=IDLE, FIFO empty, in_ready=1, out_valid=0, out_result=0, mul_opcode=0.
//  Reset mid-operation aborts any pending result and flushes the FIFO; no output follows.
//  FIFO:
//   - push on in_valid&&in_ready; count width $clog2(DEPTH)+1; pointers wrap mod DEPTH.
//   - when full, in_ready=0 even in a pop cycle; no same-cycle refill.
//   - push into empty FIFO is visible to the FSM next cycle.
//  FSM:
//   - IDLE: FIFO non-empty -> ISSUE, else IDLE.
//   - ISSUE (exactly 1 cycle): mul_opcode=01, mul_* operands = FIFO head; pop head; -> WAIT.
//   - WAIT: mul_ready is ignored-safe, since the multiplier drops it the cycle after start.
//       mul_ready=1 -> out_result<=mul_result, out_valid<=1, -> HOLD.
//   - HOLD: out_valid=1, out_result stable; out_ready=1 -> out_valid<=0, -> IDLE.
//  mul_multiplier/mul_multiplicand show the FIFO head combinationally; only sampled in ISSUE.
//  mul_ready high in IDLE/ISSUE/HOLD is ignored.
//  Latency: ISSUE at cycle c -> multiplier done at c+BW+1 -> out_valid at c+BW+2.
//  Input accept at cycle 0, block idle and empty -> ISSUE at cycle 2 -> out_valid at cycle BW+4 (8 for BW=4).
//  Arithmetic: unsigned; product fits 2*BW with no overflow; the block does no arithmetic itself.
//  Occupancy under out_ready=0: 1 op in HOLD + DEPTH queued = DEPTH+1 accepted before in_ready=0.
//  Simultaneous push+pop (ISSUE with in_valid, not full): count unchanged, both take effect.
// CONFIGURATION
//  MULT_SEQ_ZERO_BYPASS_EN defined:
//   - in IDLE, if the FIFO head has a==0 or b==0: pop it, skip ISSUE/WAIT, load out_result=0, -> HOLD.
//   - out_valid rises the cycle after IDLE sees the head.
//   - multiplier untouched; mul_opcode stays 00.
//  Not defined: every pair, including zero operands, goes through ISSUE/WAIT with full latency.
// TESTING (BW=4, DEPTH=4; each step: stimulus -> required response)
//  1 Reset: idle, out_ready=1, push a=3,b=5 at cycle 0 -> mul_opcode=01 only at cycle 2;
//    out_valid at cycle 8, out_result=15; out_valid low the cycle after.
//  2 Max: a=15,b=15 -> out_result=225; then a=1,b=1 -> 1 (FIFO pointer/state reuse).
//  3 Backpressure: out_ready=0, push 7 pairs back-to-back -> exactly 5 accepted, then in_ready=0.
//    Release out_ready -> 5 results in push order, each held stable while stalled.
//  4 Reset asserted 2 cycles into WAIT with 2 pairs queued ->
//    out_valid never rises, in_ready=1 next cycle, FIFO empty.
//  5 Zero operand a=0,b=9:
//    with MULT_SEQ_ZERO_BYPASS_EN -> out_result=0 two cycles after accept, mul_opcode never 01;
//    without the macro -> out_result=0 at cycle 8.
//  6 mul_ready tied high while IDLE/HOLD -> no spurious out_valid or FIFO pop.

Source files
------------

// File: rtl/mult_op_sequencer_if.sv
// Operand/result handshake bundle for mult_op_sequencer.
// The slave modport is the sequencer side; the master modport is the feeder/consumer side.
interface mult_op_sequencer_if #(
  parameter int BW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [2*BW-1:0] out_result;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );
endinterface

// File: rtl/mult_op_sequencer.sv
// Operand FIFO and one-at-a-time issue sequencer for shift_add_mult.
// Optional MULT_SEQ_ZERO_BYPASS_EN answers zero-operand pairs directly with 0.
module mult_op_sequencer #(
  parameter int BW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mult_op_sequencer_if.slave  bus,
  output logic [BW-1:0]       mul_multiplier,
  output logic [BW-1:0]       mul_multiplicand,
  output logic [1:0]          mul_opcode,
  input  logic [2*BW-1:0]     mul_result,
  input  logic                mul_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] mem_a [DEPTH];
  logic [BW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;
  logic            load_res;
  logic [2*BW-1:0] res_d;
  logic [2*BW-1:0] res_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;

  assign bus.in_ready   = !full;
  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.out_result = res_q;

  assign mul_multiplier   = mem_a[rd_ptr];
  assign mul_multiplicand = mem_b[rd_ptr];

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // State and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_res) res_q <= res_d;
    end
  end

  // Next state, pop strobe and multiplier start
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    mul_opcode = 2'b00;
    load_res   = 1'b0;
    res_d      = mul_result;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
`ifdef MULT_SEQ_ZERO_BYPASS_EN
          if ((mul_multiplier == '0) ||
              (mul_multiplicand == '0)) begin
            pop      = 1'b1;
            load_res = 1'b1;
            res_d    = '0;
            state_d  = S_HOLD;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        mul_opcode = 2'b01;
        pop        = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready) begin
          load_res = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Directed bench for mult_op_sequencer with a cycle-level
// shift_add_mult stand-in (start at c, done at c+BW+1).
module tb_mult_op_sequencer;

  localparam int BW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_op_sequencer_if #(.BW(BW)) bus ();

  logic [BW-1:0]   mul_multiplier;
  logic [BW-1:0]   mul_multiplicand;
  logic [1:0]      mul_opcode;
  logic [2*BW-1:0] mul_result;
  logic            mul_ready;
  logic            force_hi = 1'b0;

  mult_op_sequencer #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus.slave),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_opcode       (mul_opcode),
    .mul_result       (mul_result),
    .mul_ready        (mul_ready)
  );

  // multiplier stand-in: idle/busy for BW cycles/done for one cycle
  logic [1:0]    m_st;
  logic [2:0]    m_cnt;
  logic [BW-1:0] m_a, m_b;
  logic [2*BW-1:0] m_res;
  always @(posedge clk) begin
    if (reset) begin
      m_st <= 2'd0; m_cnt <= '0; m_res <= '0;
    end else begin
      case (m_st)
        2'd0: if (mul_opcode == 2'b01) begin
          m_a <= mul_multiplier; m_b <= mul_multiplicand;
          m_cnt <= '0; m_st <= 2'd1;
        end
        2'd1: begin
          m_cnt <= m_cnt + 1'b1;
          if (m_cnt == 3'(BW - 1)) begin
            m_st  <= 2'd2;
            m_res <= (2*BW)'(m_a) * (2*BW)'(m_b);
          end
        end
        default: m_st <= 2'd0;
      endcase
    end
  end
  assign mul_result = m_res;
  assign mul_ready  = (m_st != 2'd1) || force_hi;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    int            res;
    int            iss_cyc;
    int            n_iss;
    int            ov_cyc;
  } vec_t;

  vec_t vecs [6];

  // wait up to 'lim' cycles for out_valid; returns 1 if seen
  task automatic wait_ov(int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (bus.out_valid) begin ok = 1'b1; break; end
      step();
    end
  endtask

  initial begin
    int zc_iss, zc_ov;
    int iss_cyc, n_iss, ov_cyc, res, low_after;
    int idx, bad;
    bit ok;
    logic [BW-1:0] pa [7];
    logic [BW-1:0] pb [7];
    int r0;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    zc_iss = -1; zc_ov = 2;
`else
    zc_iss = 2;  zc_ov = 8;
`endif
    vecs[0] = '{4'd3,  4'd5,  15,  2, 1, 8};
    vecs[1] = '{4'd15, 4'd15, 225, 2, 1, 8};
    vecs[2] = '{4'd1,  4'd1,  1,   2, 1, 8};
    vecs[3] = '{4'd0,  4'd9,  0, zc_iss,
                (zc_iss < 0) ? 0 : 1, zc_ov};
    vecs[4] = '{4'd7,  4'd0,  0, zc_iss,
                (zc_iss < 0) ? 0 : 1, zc_ov};
    vecs[5] = '{4'd12, 4'd11, 132, 2, 1, 8};

    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1;
    reset = 1; step(); step();
    reset = 0; #1;

    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_result", int'(bus.out_result), 0);
    chk("rst_opcode", int'(mul_opcode), 0);
    step();

    // single-operation table: latency, issue pulse, result
    for (int v = 0; v < 6; v++) begin
      bus.in_valid = 1;
      bus.in_a = vecs[v].a; bus.in_b = vecs[v].b;
      chk($sformatf("v%0d_in_ready", v), int'(bus.in_ready), 1);
      step();
      bus.in_valid = 0;
      iss_cyc = -1; n_iss = 0; ov_cyc = -1;
      res = -1; low_after = -1;
      for (int c = 1; c <= 30; c++) begin
        if (mul_opcode == 2'b01) begin
          n_iss++;
          if (iss_cyc < 0) iss_cyc = c;
        end
        if (ov_cyc >= 0 && c == ov_cyc + 1)
          low_after = int'(bus.out_valid);
        if (bus.out_valid && ov_cyc < 0) begin
          ov_cyc = c; res = int'(bus.out_result);
        end
        step();
      end
      chk($sformatf("v%0d_issue_cyc", v), iss_cyc, vecs[v].iss_cyc);
      chk($sformatf("v%0d_n_issue", v), n_iss, vecs[v].n_iss);
      chk($sformatf("v%0d_ov_cyc", v), ov_cyc, vecs[v].ov_cyc);
      chk($sformatf("v%0d_result", v), res, vecs[v].res);
      chk($sformatf("v%0d_ov_low", v), low_after, 0);
    end

    // backpressure: DEPTH+1 accepted, results in order
    pa = '{4'd2, 4'd4, 4'd6, 4'd9, 4'd13, 4'd1, 4'd3};
    pb = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd2, 4'd3};
    bus.out_ready = 0;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      bit acc;
      bus.in_valid = 1;
      bus.in_a = pa[idx]; bus.in_b = pb[idx];
      acc = bus.in_ready;
      step();
      if (acc) idx++;
    end
    bus.in_valid = 0;
    chk("bp_accepted", idx, DEPTH + 1);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    wait_ov(40, ok);
    chk("bp_first_valid", int'(ok), 1);
    r0 = int'(bus.out_result);
    for (int c = 0; c < 6; c++) step();
    chk("bp_hold_valid", int'(bus.out_valid), 1);
    chk("bp_hold_result", int'(bus.out_result), r0);
    bus.out_ready = 1; #1;
    for (int k = 0; k < 5; k++) begin
      wait_ov(40, ok);
      chk($sformatf("bp_seen%0d", k), int'(ok), 1);
      chk($sformatf("bp_res%0d", k), int'(bus.out_result),
          int'(pa[k]) * int'(pb[k]));
      step();
    end
    for (int c = 0; c < 20; c++) step();
    chk("bp_drained", int'(bus.out_valid), 0);

    // reset two cycles into WAIT with two pairs queued
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1;
      bus.in_a = 4'(c + 2); bus.in_b = 4'(c + 5);
      step();
    end
    bus.in_valid = 0;
    step(); step();
    reset = 1; step();
    reset = 0; #1;
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.out_valid || mul_opcode == 2'b01) bad++;
      step();
    end
    chk("rst_mid_quiet", bad, 0);

    // mul_ready forced high while idle and while holding
    force_hi = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) bad++;
      step();
    end
    chk("idle_ready_hi", bad, 0);
    force_hi = 0;
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_a = 4'd2; bus.in_b = 4'd3;
    step();
    bus.in_a = 4'd4; bus.in_b = 4'd5;
    step();
    bus.in_valid = 0;
    wait_ov(40, ok);
    chk("hold_seen", int'(ok), 1);
    force_hi = 1;
    for (int c = 0; c < 6; c++) step();
    chk("hold_hi_valid", int'(bus.out_valid), 1);
    chk("hold_hi_result", int'(bus.out_result), 6);
    force_hi = 0;
    bus.out_ready = 1;
    step();
    wait_ov(40, ok);
    chk("hold_next_seen", int'(ok), 1);
    chk("hold_next_result", int'(bus.out_result), 20);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
